// File: rtl/qsn_pkg.sv
// Shared definitions for the QSN cyclic shift pipeline: default geometry,
// pipeline latency, shift direction type and the shift/merge-select helpers.
package qsn_pkg;

    localparam int unsigned QSN_PC      = 51;
    localparam int unsigned QSN_W       = 4;
    localparam int unsigned QSN_SHIFT_W = $clog2(QSN_PC);
    localparam int unsigned QSN_LAT     = 3;

    typedef enum logic {
        QSN_FWD = 1'b0,
        QSN_INV = 1'b1
    } qsn_dir_e;

    // Effective rotation amount. Out-of-range shifts collapse to a pass-through
    // regardless of direction; inverse of 0 stays 0 rather than becoming pc.
    function automatic int unsigned qsn_eff_shift(input int unsigned s,
                                                  input qsn_dir_e    dir,
                                                  input int unsigned pc);
        int unsigned e;
        if (s >= pc) begin
            e = 0;
        end else if (dir == QSN_INV && s != 0) begin
            e = pc - s;
        end else begin
            e = s;
        end
        return e;
    endfunction

    // One bit of the merge select vector: 1 selects the left-shifted path.
    // Element i comes from the left path while i + e still lands inside the vector.
    function automatic logic qsn_sel_bit(input int unsigned i,
                                         input int unsigned e,
                                         input int unsigned pc);
        return (i < pc - e);
    endfunction

endpackage

// File: rtl/qsn_merge_generic.sv
// Combinational QSN merge: picks each output element from the left or right
// shifted vector; the top element always comes from the right path.
module qsn_merge_generic
    import qsn_pkg::*;
#(
    parameter int unsigned PC = QSN_PC,
    parameter int unsigned W  = QSN_W
) (
    input  logic [PC-2:0][W-1:0] left_i,
    input  logic [PC-1:0][W-1:0] right_i,
    input  logic [PC-2:0]        sel_i,
    output logic [PC-1:0][W-1:0] merged_o
);

    for (genvar gi = 0; gi < PC - 1; gi++) begin : g_mux
        assign merged_o[gi] = sel_i[gi] ? left_i[gi] : right_i[gi];
    end

    assign merged_o[PC-1] = right_i[PC-1];

endmodule

// File: rtl/qsn_cyc_shift_pipe.sv
// Pipelined QSN cyclic shifter: out[i] = in[(i + e) mod PC], with forward /
// inverse shift mode, out-of-range detection and valid/ready flow control.
// Stages: S1 data + effective shift, S2 left/right partials + select, S3 merge.
module qsn_cyc_shift_pipe
    import qsn_pkg::*;
#(
    parameter int unsigned PC      = QSN_PC,
    parameter int unsigned W       = QSN_W,
    parameter int unsigned SHIFT_W = $clog2(PC)
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC*W-1:0]     in_data,
    input  logic [SHIFT_W-1:0]  in_shift,
    input  logic                in_inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC*W-1:0]     out_data,
    output logic                err_range
);

    localparam int unsigned IDX_W = $clog2(PC);

    logic                 en;
    logic                 accept;
    logic                 oor;
    logic [SHIFT_W-1:0]   e_d;

    logic                 s1_valid_q;
    logic [PC-1:0][W-1:0] s1_data_q;
    logic [SHIFT_W-1:0]   s1_e_q;

    logic [31:0]          e_ext;
    logic [31:0]          r_ext;
    logic [PC-2:0][W-1:0] left_d;
    logic [PC-1:0][W-1:0] right_d;
    logic [PC-2:0]        sel_d;

    logic                 s2_valid_q;
    logic [PC-2:0][W-1:0] left_q;
    logic [PC-1:0][W-1:0] right_q;
    logic [PC-2:0]        sel_q;

    logic [PC-1:0][W-1:0] merge_d;
    logic                 s3_valid_q;
    logic [PC-1:0][W-1:0] s3_data_q;

    logic                 err_range_q;

    // Whole pipeline advances together; a held output freezes every stage.
    assign en       = ~s3_valid_q | out_ready;
    assign in_ready = en;
    assign accept   = in_valid & en;
    assign oor      = (32'(in_shift) >= PC);
    assign e_d      = SHIFT_W'(qsn_eff_shift(32'(in_shift), qsn_dir_e'(in_inv), PC));

    // S1: capture the input vector and its effective shift.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_e_q     <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_data;
                s1_e_q    <= e_d;
            end
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            err_range_q <= 1'b0;
        end else if (accept && oor) begin
            err_range_q <= 1'b1;
        end
    end

    // Right path rotates by (PC - e) mod PC so that e = 0 yields the input itself.
    assign e_ext = 32'(s1_e_q);
    assign r_ext = (e_ext == 32'd0) ? 32'd0 : (PC - e_ext);

    // Left shifter and merge select: element i takes in[i + e] while in range.
    for (genvar gi = 0; gi < PC - 1; gi++) begin : g_left
        logic [31:0] lsum;
        assign lsum        = 32'(gi) + e_ext;
        assign left_d[gi]  = (lsum < PC) ? s1_data_q[lsum[IDX_W-1:0]] : '0;
        assign sel_d[gi]   = qsn_sel_bit(32'(gi), e_ext, PC);
    end

    // Right shifter: element i takes in[i - r]; a wrapped difference means out of range.
    for (genvar gi = 0; gi < PC; gi++) begin : g_right
        logic [31:0] rdiff;
        assign rdiff       = 32'(gi) - r_ext;
        assign right_d[gi] = (rdiff < PC) ? s1_data_q[rdiff[IDX_W-1:0]] : '0;
    end

    // S2: register the two partial vectors and the select.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            sel_q      <= '0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                left_q  <= left_d;
                right_q <= right_d;
                sel_q   <= sel_d;
            end
        end
    end

    qsn_merge_generic #(
        .PC (PC),
        .W  (W)
    ) u_merge (
        .left_i   (left_q),
        .right_i  (right_q),
        .sel_i    (sel_q),
        .merged_o (merge_d)
    );

    // S3: register the merged result; it drives the outputs directly.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
        end else if (en) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_data_q <= merge_d;
            end
        end
    end

    assign out_valid = s3_valid_q;
    assign out_data  = s3_data_q;
    assign err_range = err_range_q;

endmodule

// File: tb/tb_qsn_cyc_shift_pipe.sv
// Self-checking bench for qsn_cyc_shift_pipe (PC=51, W=4) using a reference
// rotation model and a queue of expected output vectors.
module tb_qsn_cyc_shift_pipe;
    import qsn_pkg::*;

    localparam int PC  = 51;
    localparam int W   = 4;
    localparam int SW  = $clog2(PC);
    localparam int PCW = PC * W;

    logic           sys_clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [PCW-1:0] in_data;
    logic [SW-1:0]  in_shift;
    logic           in_inv;
    logic           out_valid;
    logic           out_ready;
    logic [PCW-1:0] out_data;
    logic           err_range;

    int n_vec  = 0;
    int n_miss = 0;
    logic [PCW-1:0] sb_q[$];

    qsn_cyc_shift_pipe #(
        .PC      (PC),
        .W       (W),
        .SHIFT_W (SW)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_range (err_range)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference: out[i] = in[(i + e) mod PC], e derived directly from the shift rules.
    function automatic logic [PCW-1:0] ref_shift(input logic [PCW-1:0] v, input int s, input bit inv);
        logic [PCW-1:0] r;
        int e;
        if (s >= PC)  e = 0;
        else if (inv) e = (PC - s) % PC;
        else          e = s;
        for (int i = 0; i < PC; i++) r[i*W +: W] = v[((i + e) % PC)*W +: W];
        return r;
    endfunction

    function automatic logic [PCW-1:0] ramp_vec();
        logic [PCW-1:0] v;
        for (int i = 0; i < PC; i++) v[i*W +: W] = W'(i % 16);
        return v;
    endfunction

    function automatic logic [PCW-1:0] rand_vec();
        logic [PCW-1:0] v;
        for (int i = 0; i < PC; i++) v[i*W +: W] = W'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; in_inv = 1'b0; out_ready = 1'b1;
        #2;
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0) begin n_miss++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_vec++; if (err_range !== 1'b0) begin n_miss++; $display("FAIL reset_err_range got %b want 0", err_range); end
        n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge sys_clk); rst = 1'b0;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_forward();
        logic [PCW-1:0] vec, exp;
        logic [W-1:0] el;
        int cyc;
        vec = ramp_vec(); exp = ref_shift(vec, 3, 1'b0);
        out_ready = 1'b1; in_valid = 1'b1; in_data = vec; in_shift = SW'(3); in_inv = 1'b0;
        @(posedge sys_clk); #1; in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin @(posedge sys_clk); #1; cyc++; end
        n_vec++; if (cyc != int'(QSN_LAT)) begin n_miss++; $display("FAIL fwd_latency got %0d want %0d", cyc, QSN_LAT); end
        n_vec++; if (out_data !== exp) begin n_miss++; $display("FAIL fwd_data got %h want %h", out_data, exp); end
        el = out_data[0*W +: W];
        n_vec++; if (el !== 4'd3) begin n_miss++; $display("FAIL fwd_el0 got %0d want 3", el); end
        el = out_data[47*W +: W];
        n_vec++; if (el !== 4'd2) begin n_miss++; $display("FAIL fwd_el47 got %0d want 2", el); end
        el = out_data[48*W +: W];
        n_vec++; if (el !== 4'd0) begin n_miss++; $display("FAIL fwd_el48 got %0d want 0", el); end
        n_vec++; if (err_range !== 1'b0) begin n_miss++; $display("FAIL fwd_err got %b want 0", err_range); end
        @(posedge sys_clk); #1;
    endtask

    task automatic test_inverse();
        logic [PCW-1:0] vec, exp;
        logic [W-1:0] el;
        int cyc;
        vec = ramp_vec(); exp = ref_shift(vec, 3, 1'b1);
        out_ready = 1'b1; in_valid = 1'b1; in_data = vec; in_shift = SW'(3); in_inv = 1'b1;
        @(posedge sys_clk); #1; in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin @(posedge sys_clk); #1; cyc++; end
        n_vec++; if (cyc != int'(QSN_LAT)) begin n_miss++; $display("FAIL inv_latency got %0d want %0d", cyc, QSN_LAT); end
        n_vec++; if (out_data !== exp) begin n_miss++; $display("FAIL inv_data got %h want %h", out_data, exp); end
        el = out_data[0*W +: W];
        n_vec++; if (el !== 4'd0) begin n_miss++; $display("FAIL inv_el0 got %0d want 0", el); end
        el = out_data[3*W +: W];
        n_vec++; if (el !== 4'd0) begin n_miss++; $display("FAIL inv_el3 got %0d want 0", el); end
        el = out_data[2*W +: W];
        n_vec++; if (el !== 4'd2) begin n_miss++; $display("FAIL inv_el2 got %0d want 2", el); end
        @(posedge sys_clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [PCW-1:0] exp;
        int sent, got, first, last;
        sent = 0; got = 0; first = -1; last = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            if (sent < PC) begin
                in_valid = 1'b1; in_data = rand_vec(); in_shift = SW'(sent); in_inv = sent[0];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge sys_clk);
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_miss++; $display("FAIL b2b_unexpected got %h want none", out_data);
                end else begin
                    exp = sb_q.pop_front();
                    if (out_data !== exp) begin n_miss++; $display("FAIL b2b_data beat %0d got %h want %h", got, out_data, exp); end
                end
                if (first < 0) first = cyc;
                last = cyc; got++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_shift(in_data, int'(in_shift), in_inv)); sent++;
            end
            @(posedge sys_clk); #1;
        end
        in_valid = 1'b0;
        n_vec++; if (got != PC) begin n_miss++; $display("FAIL b2b_count got %0d want %0d", got, PC); end
        n_vec++; if (first != 3) begin n_miss++; $display("FAIL b2b_first_cycle got %0d want 3", first); end
        n_vec++; if (last != 3 + PC - 1) begin n_miss++; $display("FAIL b2b_last_cycle got %0d want %0d", last, 3 + PC - 1); end
        n_vec++; if (sb_q.size() != 0) begin n_miss++; $display("FAIL b2b_leftover got %0d want 0", sb_q.size()); end
        sb_q.delete();
    endtask

    task automatic test_backpressure();
        logic [PCW-1:0] bvec[4];
        logic [PCW-1:0] hold, exp;
        int bs[4];
        bit bi[4];
        bit have_hold, exp_rdy;
        int idx, drained;
        for (int k = 0; k < 4; k++) begin
            bvec[k] = rand_vec(); bs[k] = $urandom_range(0, PC - 1); bi[k] = 1'($urandom_range(0, 1));
        end
        idx = 0; drained = 0; have_hold = 1'b0; hold = '0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin in_data = bvec[idx]; in_shift = SW'(bs[idx]); in_inv = bi[idx]; end
            @(negedge sys_clk);
            exp_rdy = !out_valid;
            n_vec++; if (in_ready !== exp_rdy) begin n_miss++; $display("FAIL bp_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_rdy); end
            if (out_valid) begin
                if (!have_hold) begin
                    hold = out_data; have_hold = 1'b1;
                end else begin
                    n_vec++; if (out_data !== hold) begin n_miss++; $display("FAIL bp_hold cyc %0d got %h want %h", cyc, out_data, hold); end
                end
            end
            if (in_valid && in_ready) begin sb_q.push_back(ref_shift(in_data, int'(in_shift), in_inv)); idx++; end
            @(posedge sys_clk); #1;
        end
        n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL bp_stalled_valid got %b want 1", out_valid); end
        n_vec++; if (idx != 3) begin n_miss++; $display("FAIL bp_accepted_in_stall got %0d want 3", idx); end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && (idx < 4 || sb_q.size() != 0); cyc++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin in_data = bvec[idx]; in_shift = SW'(bs[idx]); in_inv = bi[idx]; end
            @(negedge sys_clk);
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_miss++; $display("FAIL bp_unexpected got %h want none", out_data);
                end else begin
                    exp = sb_q.pop_front();
                    if (out_data !== exp) begin n_miss++; $display("FAIL bp_data beat %0d got %h want %h", drained, out_data, exp); end
                end
                drained++;
            end
            if (in_valid && in_ready) begin sb_q.push_back(ref_shift(in_data, int'(in_shift), in_inv)); idx++; end
            @(posedge sys_clk); #1;
        end
        in_valid = 1'b0;
        n_vec++; if (drained != 4) begin n_miss++; $display("FAIL bp_drained got %0d want 4", drained); end
        sb_q.delete();
    endtask

    task automatic test_range();
        int ss[4];
        bit si[4];
        logic [PCW-1:0] vin[4];
        logic [PCW-1:0] exp;
        bit err_exp;
        int idx, drained;
        ss = '{51, 5, 63, 0}; si = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) vin[k] = rand_vec();
        idx = 0; drained = 0; err_exp = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin in_data = vin[idx]; in_shift = SW'(ss[idx]); in_inv = si[idx]; end
            @(negedge sys_clk);
            n_vec++; if (err_range !== err_exp) begin n_miss++; $display("FAIL range_err cyc %0d got %b want %b", cyc, err_range, err_exp); end
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_miss++; $display("FAIL range_unexpected got %h want none", out_data);
                end else begin
                    exp = sb_q.pop_front();
                    if (out_data !== exp) begin n_miss++; $display("FAIL range_data beat %0d got %h want %h", drained, out_data, exp); end
                end
                drained++;
            end
            if (in_valid && in_ready) begin
                // out-of-range beats pass through unchanged
                sb_q.push_back((ss[idx] >= PC) ? in_data : ref_shift(in_data, ss[idx], si[idx]));
                if (ss[idx] >= PC) err_exp = 1'b1;
                idx++;
            end
            @(posedge sys_clk); #1;
        end
        in_valid = 1'b0;
        n_vec++; if (drained != 4) begin n_miss++; $display("FAIL range_drained got %0d want 4", drained); end
        n_vec++; if (err_range !== 1'b1) begin n_miss++; $display("FAIL range_sticky got %b want 1", err_range); end
        sb_q.delete();
    endtask

    task automatic test_reset_midstream();
        logic [PCW-1:0] vec, exp;
        int cyc;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = rand_vec(); in_shift = SW'($urandom_range(0, PC - 1)); in_inv = 1'b0;
            @(posedge sys_clk); #1;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0) begin n_miss++; $display("FAIL mid_rst_data got %h want 0", out_data); end
        n_vec++; if (err_range !== 1'b0) begin n_miss++; $display("FAIL mid_rst_err got %b want 0", err_range); end
        n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
        @(negedge sys_clk); #1 rst = 1'b0;
        @(posedge sys_clk); #1;
        vec = rand_vec(); exp = ref_shift(vec, 17, 1'b1);
        in_valid = 1'b1; in_data = vec; in_shift = SW'(17); in_inv = 1'b1;
        @(posedge sys_clk); #1; in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin @(posedge sys_clk); #1; cyc++; end
        n_vec++; if (cyc != int'(QSN_LAT)) begin n_miss++; $display("FAIL mid_latency got %0d want %0d", cyc, QSN_LAT); end
        n_vec++; if (out_data !== exp) begin n_miss++; $display("FAIL mid_data got %h want %h", out_data, exp); end
        @(posedge sys_clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL mid_drain_valid got %b want 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_back_to_back();
        test_backpressure();
        test_range();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/qsn_cyc_shift_pipe.md
Name: qsn_cyc_shift_pipe

Overview:
- Parametrised, pipelined QSN (QC-LDPC shift network) cyclic shifter for Pc-wide messages of W bits each.
- Built from left shifter, right shifter and merge stages, with registered stages and valid/ready flow control.
- Generalises the fixed Pc=51 combinational merge to any Pc and any message width.
- Adds forward/inverse shift mode and out-of-range detection.
- Sits between the column-message memory and the check-node units; the inverse mode is used for write-back.

Parameters:
- PC, 51, circulant size (number of messages).
- W, 4, bits per message (quantisation size).
- SHIFT_W, $clog2(PC), width of the shift factor.

Ports:
- sys_clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  PC*W  message vector; element i occupies bits [i*W +: W].
- in_shift  in  SHIFT_W  cyclic shift factor s.
- in_inv  in  1  0 = forward shift, 1 = inverse shift.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts a beat.
- out_data  out  PC*W  shifted vector.
- err_range  out  1  sticky flag: an in_shift >= PC was accepted.

Behaviour:
- Function per accepted beat:
  - Effective shift: e = s when in_inv=0; e = (PC - s) mod PC when in_inv=1.
  - Output: out element i = in element (i+e) mod PC, for i in 0..PC-1.
- Out-of-range shift (in_shift >= PC): e is forced to 0 (pass-through, in_inv ignored) and err_range is set on that beat.
- Pipeline, 3 stages:
  - S1 registers data and e.
  - S2 registers the left-shift and right-shift partial vectors plus the merge select vector sel[PC-2:0].
  - S3 registers the merge result.
- Merge select rule: sel[i] = 1 (take the left path) when i < PC-e, else the right path. The top element always comes from the right path, as in the existing merge.
- Latency: 3 cycles from the accepting edge to out_valid, with no stalls.
- Flow control:
  - Global stage enable en = ~out_valid | out_ready.
  - in_ready = en. A beat is accepted when in_valid & in_ready.
  - When en=0 all stage registers hold. Bubbles are not collapsed.
  - Each stage carries its own valid bit and advances on en.
  - out_data stays stable while out_valid=1 and out_ready=0.
- Throughput: 1 beat/cycle when out_ready is held high.
- Reset (asynchronous, any time including mid-stream):
  - All stage valid bits clear; out_valid=0; out_data=0; err_range=0; in_ready=1 after reset.
  - In-flight beats are discarded.
- err_range is cleared only by rst.
- Simultaneous events:
  - Input accepted while S3 is drained in the same cycle: both take effect; no loss or duplication.
  - e=0: out_data = in_data.
  - Inverse mode with s=0: e=0.
- No combinational path from out_ready to out_data. The only combinational path is out_ready -> in_ready.

Decomposition:
- Shared package qsn_pkg holds:
  - the PC, W and SHIFT_W defaults;
  - the QSN_LAT=3 constant;
  - a function computing e from (s, inv, PC);
  - a function producing the sel vector.
- One natural sub-module, qsn_merge_generic: a parametrised combinational merge (PC, W) taking left[PC-2:0], right[PC-1:0] and sel[PC-2:0]. It is instantiated once, feeding S3.
- The left/right shifters are written inline as generate loops.

Test Plan:
- PC=51, W=4, in element i = i mod 16; s=3, inv=0, out_ready=1 -> after 3 cycles element 0 = 3, element 47 = 50 mod 16 = 2, element 48 = 0; err_range=0.
- Same vector, s=3, inv=1 -> e=48: element 0 = 48 mod 16 = 0, element 3 = 51 mod 51 = 0, element 2 = 50 mod 16 = 2.
- Back-to-back beats with s=0,1,...,50 at out_ready=1 -> 51 outputs in order, each matching the reference model, one per cycle after a 3-cycle fill.
- Backpressure: out_ready=0 for 5 cycles while 4 beats are offered -> in_ready drops once out_valid=1, out_data is held, no beat is lost or duplicated; order is preserved after release.
- s=51 -> output equals input, err_range goes 1 and stays 1 across later valid beats until rst.
- rst pulse while 3 beats are in flight -> out_valid goes 0 asynchronously, out_data=0, err_range=0; the next accepted beat emerges exactly 3 cycles later.
